// File: rtl/game_pkg.sv
// Shared definitions for the frame draw scheduler: screen geometry, sprite
// colours and the scheduler state encoding.
package game_pkg;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;
    localparam int CNT_W = 5;

    localparam logic [COL_W-1:0] BG_COL   = 3'b000;
    localparam logic [COL_W-1:0] BALL_COL = 3'b111;
    localparam logic [COL_W-1:0] PAD_COL  = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE_BALL,
        S_ERASE_PAD,
        S_UPDATE,
        S_LATCH,
        S_DRAW_BALL,
        S_DRAW_PAD
    } sched_state_t;

    function automatic logic is_walk_state(input sched_state_t s);
        return (s == S_ERASE_BALL) || (s == S_ERASE_PAD) ||
               (s == S_DRAW_BALL)  || (s == S_DRAW_PAD);
    endfunction

endpackage

// File: rtl/frame_draw_sched_walker.sv
// Row-major pixel walker: steps (cx, cy) over a width x height rectangle,
// one pixel per cycle, restarting whenever start is sampled.
module shape_walker
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] height,
    output logic [CNT_W-1:0] cx,
    output logic [CNT_W-1:0] cy,
    output logic             active,
    output logic             last
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] w_q;
    logic [CNT_W-1:0] h_q;
    logic             row_end;

    assign row_end = (cx == w_q - ONE);
    assign last    = active && row_end && (cy == h_q - ONE);

    // start wins over last so back-to-back walks have no gap cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cx     <= '0;
            cy     <= '0;
            w_q    <= '0;
            h_q    <= '0;
            active <= 1'b0;
        end else if (start) begin
            cx     <= '0;
            cy     <= '0;
            w_q    <= width;
            h_q    <= height;
            active <= 1'b1;
        end else if (active) begin
            if (last) begin
                cx     <= '0;
                cy     <= '0;
                active <= 1'b0;
            end else if (row_end) begin
                cx <= '0;
                cy <= cy + ONE;
            end else begin
                cx <= cx + ONE;
            end
        end
    end

endmodule

// File: rtl/frame_draw_sched.sv
// Per-frame scheduler sharing the VGA plot port between ball and paddle:
// erase old sprites, pulse the datapath, latch new positions, redraw.
module frame_draw_sched #(
    parameter int                 X_W      = game_pkg::X_W,
    parameter int                 Y_W      = game_pkg::Y_W,
    parameter int                 COL_W    = game_pkg::COL_W,
    parameter int                 BALL_SZ  = 4,
    parameter int                 PAD_W    = 2,
    parameter int                 PAD_H    = 16,
    parameter logic [COL_W-1:0]   BG_COL   = game_pkg::BG_COL,
    parameter logic [COL_W-1:0]   BALL_COL = game_pkg::BALL_COL,
    parameter logic [COL_W-1:0]   PAD_COL  = game_pkg::PAD_COL
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             frame_tick,
    input  logic             enable,
    input  logic [X_W-1:0]   ball_x,
    input  logic [Y_W-1:0]   ball_y,
    input  logic [X_W-1:0]   pad_x,
    input  logic [Y_W-1:0]   pad_y,
    output logic             update_pos,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [COL_W-1:0] colour,
    output logic             plot,
    output logic             busy,
    output logic             overrun
);

    import game_pkg::*;

    sched_state_t     state;
    sched_state_t     next_state;

    logic             walk_start;
    logic             walk_active;
    logic             walk_last;
    logic [CNT_W-1:0] walk_w;
    logic [CNT_W-1:0] walk_h;
    logic [CNT_W-1:0] cx;
    logic [CNT_W-1:0] cy;

    logic [X_W-1:0]   snap_bx;
    logic [Y_W-1:0]   snap_by;
    logic [X_W-1:0]   snap_px;
    logic [Y_W-1:0]   snap_py;
    logic             snap_valid;

    logic [X_W-1:0]   org_x;
    logic [Y_W-1:0]   org_y;
    logic [COL_W-1:0] pix_col;
    logic             pix_on;

    shape_walker u_walker (
        .clk    (clk),
        .resetn (resetn),
        .start  (walk_start),
        .width  (walk_w),
        .height (walk_h),
        .cx     (cx),
        .cy     (cy),
        .active (walk_active),
        .last   (walk_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:       if (frame_tick && enable)
                              next_state = snap_valid ? S_ERASE_BALL : S_UPDATE;
            S_ERASE_BALL: if (walk_last) next_state = S_ERASE_PAD;
            S_ERASE_PAD:  if (walk_last) next_state = S_UPDATE;
            S_UPDATE:     next_state = S_LATCH;
            S_LATCH:      next_state = S_DRAW_BALL;
            S_DRAW_BALL:  if (walk_last) next_state = S_DRAW_PAD;
            S_DRAW_PAD:   if (walk_last) next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    // The walker is restarted on the same edge the FSM enters a walk state.
    always_comb begin
        walk_start = (next_state != state) && is_walk_state(next_state);
        walk_w     = CNT_W'(PAD_W);
        walk_h     = CNT_W'(PAD_H);
        if (next_state == S_ERASE_BALL || next_state == S_DRAW_BALL) begin
            walk_w = CNT_W'(BALL_SZ);
            walk_h = CNT_W'(BALL_SZ);
        end
    end

    always_comb begin
        org_x   = snap_px;
        org_y   = snap_py;
        pix_col = BG_COL;
        pix_on  = 1'b0;
        case (state)
            S_ERASE_BALL: begin
                org_x  = snap_bx;
                org_y  = snap_by;
                pix_on = walk_active;
            end
            S_ERASE_PAD:  pix_on = walk_active;
            S_DRAW_BALL: begin
                org_x   = snap_bx;
                org_y   = snap_by;
                pix_col = BALL_COL;
                pix_on  = walk_active;
            end
            S_DRAW_PAD: begin
                pix_col = PAD_COL;
                pix_on  = walk_active;
            end
            default: ;
        endcase
    end

    // update_pos is registered from next_state so it coincides with UPDATE,
    // letting LATCH see the datapath's registered result one cycle later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            snap_bx    <= '0;
            snap_by    <= '0;
            snap_px    <= '0;
            snap_py    <= '0;
            snap_valid <= 1'b0;
            update_pos <= 1'b0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            update_pos <= (next_state == S_UPDATE);
            busy       <= (state != S_IDLE);
            overrun    <= frame_tick && (state != S_IDLE);
            plot       <= pix_on;
            colour     <= pix_col;
            x          <= org_x + X_W'(cx);
            y          <= org_y + Y_W'(cy);
            if (state == S_LATCH) begin
                snap_bx    <= ball_x;
                snap_by    <= ball_y;
                snap_px    <= pad_x;
                snap_py    <= pad_y;
                snap_valid <= 1'b1;
            end
        end
    end

endmodule
